// File: rtl/ram_pkg.sv
// ram_pkg: shared sizing constants for the RAM tiers (ram8 and the larger banks built from it)
// No ports; imported by the RAM modules.
package ram_pkg;
    localparam int RAM_WIDTH   = 16;
    localparam int RAM8_ADDR_W = 3;
    localparam int RAM8_DEPTH  = 8;
endpackage

// File: rtl/register16.sv
// register16: WIDTH-bit register with synchronous active-high reset and load enable
// Ports: clk (clock), reset (sync clear), load (write enable), in (data in), out (stored value)
module register16
    import ram_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk)
        r_q <= reset ? '0 : load ? in : r_q;

    assign out = r_q;
endmodule

// File: rtl/ram8.sv
// ram8: 8-word register-file memory with one write per clock and a combinational read port
// Ports: clk (clock), reset (sync clear of all words), in (write data), sel (read/write address),
//        load (write enable for word[sel]), out (word[sel], combinational)
module ram8
    import ram_pkg::*;
#(
    parameter int WIDTH  = RAM_WIDTH,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] sel,
    input  logic              load,
    output logic [WIDTH-1:0]  out
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] w_word [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register16 #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .reset(reset),
            .load (load && (sel == ADDR_W'(i))),
            .in   (in),
            .out  (w_word[i])
        );
    end

    // Read is a plain mux on the stored words: no bypass, so a same-cycle write shows only after the edge.
    assign out = w_word[sel];
endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed self-checking bench for ram8
module tb_ram8;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in = '0;
    logic [2:0]  sel = '0;
    logic        load = 1'b0;
    logic [15:0] out;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] fill [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                              16'h5555, 16'h6666, 16'h7777, 16'h8888};

    ram8 dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .sel  (sel),
        .load (load),
        .out  (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1 check($sformatf("reset_sel%0d", i), out, 16'h0000);
        end

        for (int i = 0; i < 8; i++) begin
            sel  = 3'(i);
            in   = fill[i];
            load = 1'b1;
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1 check($sformatf("fill_sel%0d", i), out, fill[i]);
        end

        in = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1 check($sformatf("noload_sel%0d", i), out, fill[i]);
        end

        sel  = 3'd3;
        in   = 16'hABCD;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("overwrite_sel3", out, 16'hABCD);
        sel = 3'd2;
        #1 check("isolate_sel2", out, 16'h3333);
        sel = 3'd4;
        #1 check("isolate_sel4", out, 16'h5555);

        sel  = 3'd5;
        in   = 16'hBEEF;
        load = 1'b1;
        #1 check("rw_before_edge", out, 16'h6666);
        tick();
        load = 1'b0;
        check("rw_after_edge", out, 16'hBEEF);

        reset = 1'b1;
        load  = 1'b1;
        sel   = 3'd7;
        in    = 16'h1234;
        #1 check("reset_pre_edge", out, 16'h8888);
        tick();
        reset = 1'b0;
        load  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            sel = 3'(i);
            #1 check($sformatf("rstprio_sel%0d", i), out, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
